aes256_dec_fsm: RTL and testbench
=================================

AES256_DEC_FSM -- requirements
Module: aes256_dec_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: resetn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: ctrl_dataIn_dec  in  1  ciphertext valid strobe.
REQ-004 SHALL have ports: dec_dataIn  in  128  ciphertext, state byte k = bits [8k+7:8k], column-major (row k%4, col k/4).
REQ-005 SHALL have ports: dec_keyAddr  out  4  round-key index to external key ROM.
REQ-006 SHALL have ports: dec_keyIn  in  128  round key, same byte mapping as dec_dataIn, valid 1 cycle after dec_keyAddr changes.
REQ-007 SHALL have ports: dec_dataOut  out  128  plaintext, same byte mapping.
REQ-008 SHALL have ports: ctrl_dataOut_dec  out  1  one-cycle done pulse qualifying dec_dataOut.

Function
REQ-009 SHALL implement the AES-256 inverse cipher: ARK(k14); for r=13..1: InvShiftRows, InvSubBytes, ARK(kr), InvMixColumns; final: InvShiftRows, InvSubBytes, ARK(k0).
REQ-010 SHALL use FSM states IDLE, ARK, ISHF, ISUB, ISUBW, IMIX, DONE; no other reachable states.
REQ-011 IDLE: sampling ctrl_dataIn_dec=1 (edge E0) latches dec_dataIn into state register, sets round=14, goes to ARK; otherwise stays.
REQ-012 ARK (1 cycle): state ^= dec_keyIn; if round==14 then round<=13, go ISHF; elif round>=1 go IMIX; else (round==0) go DONE.
REQ-013 ISHF (1 cycle): InvShiftRows, row i rotated right by i byte positions; go ISUB.
REQ-014 ISUB (16 cycles): byte counter 0..15 drives inverse S-box ROM address; ROM read latency 1 cycle; result written to byte cnt-1; at cnt==15 go ISUBW.
REQ-015 ISUBW (1 cycle): writes byte 15; go ARK.
REQ-016 IMIX (1 cycle): InvMixColumns (GF(2^8), poly 0x11B, coeffs 0e,0b,0d,09); round<=round-1; go ISHF.
REQ-017 DONE (1 cycle): registers state into dec_dataOut, pulses ctrl_dataOut_dec; go IDLE.
REQ-018 dec_keyAddr SHALL equal round counter (14 in IDLE and initial ARK); changes at least 2 cycles before the ARK that consumes it.
REQ-019 Latency SHALL be fixed: dec_dataOut/ctrl_dataOut_dec update on edge E0+281 (1 ARK + 13x20 + 19 round cycles + DONE).
REQ-020 ctrl_dataIn_dec while not in IDLE (including DONE) SHALL be ignored; no queuing; next accept earliest in cycle after DONE.
REQ-021 dec_dataOut SHALL hold its value until the next DONE; ctrl_dataOut_dec high exactly 1 cycle per block.
REQ-022 Round counter SHALL be 4 bits, never wraps below 0; ISUB byte counter 4 bits, cleared on ISUB entry.

Reset
REQ-023 resetn low at a rising edge SHALL force: state IDLE, round=14, byte counter 0, dec_dataOut=0, ctrl_dataOut_dec=0, state register 0.
REQ-024 Reset mid-operation SHALL abort the block with no done pulse; first accept possible on the first edge with resetn high.

Structure
REQ-025 Shared package aes256_pkg SHALL hold AES_ROUNDS=14, N=16, byte-matrix typedef, FSM state enum, InvShiftRows/InvMixColumns/xtime functions.
REQ-026 Single sub-module mod_dec_rom256 (256x8 inverse S-box, registered output, ports clk, resetn, addr, data).

Verification
REQ-027 FIPS-197 C.3: key ROM loaded with expansion of key 000102..1f; dec_dataIn=128'h8960494b9049fcea_bf456751cab7a28e, strobe 1 cycle -> at E0+281 dec_dataOut=128'hffeeddccbbaa9988_7766554433221100, ctrl pulse 1 cycle.
REQ-028 Sequence check: dec_keyAddr observed 14,13,...,0 in order, each stable during its ARK.
REQ-029 Strobe re-asserted every cycle during a block -> exactly one done pulse at E0+281; next block accepted only after DONE, second result correct.
REQ-030 resetn low for 1 cycle at E0+150 -> no pulse, dec_dataOut=0, FSM in IDLE; new strobe then completes normally at new E0+281.
REQ-031 All-zero ciphertext with all-zero round keys -> output matches golden model; dec_dataOut held unchanged for 100 idle cycles after pulse.

Source files
------------

// File: rtl/aes256_pkg.sv
// -----------------------------------------------------------------------------
// aes256_pkg
// Shared definitions for the AES-256 inverse-cipher block:
//   - AES_ROUNDS / N     : round count and bytes per state
//   - byte_t, byte_mat_t : byte and 4x4 byte-matrix types. The matrix is packed
//                          [col][row][bit], so byte k of a 128-bit vector lands
//                          on row k%4, column k/4.
//   - dec_state_t        : controller FSM states
//   - xtime, gf_mul4, inv_shift_rows, inv_mix_columns : GF(2^8) helpers
// -----------------------------------------------------------------------------
package aes256_pkg;

  localparam int AES_ROUNDS = 14;
  localparam int N          = 16;

  typedef logic [7:0]                byte_t;
  typedef logic [3:0][3:0][7:0]      byte_mat_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARK   = 3'd1,
    ISHF  = 3'd2,
    ISUB  = 3'd3,
    ISUBW = 3'd4,
    IMIX  = 3'd5,
    DONE  = 3'd6
  } dec_state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B).
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant; enough for the 09/0b/0d/0e coefficients.
  function automatic byte_t gf_mul4(input byte_t b, input logic [3:0] k);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  // Row r is rotated right by r positions: out(r, c) = in(r, c - r).
  function automatic byte_mat_t inv_shift_rows(input byte_mat_t s);
    byte_mat_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[c][r] = s[2'(c - r)][r];
      end
    end
    return o;
  endfunction

  // Each output row is the circulant {0e,0b,0d,09} applied to its column.
  function automatic byte_mat_t inv_mix_columns(input byte_mat_t s);
    byte_mat_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[c][r] = gf_mul4(s[c][r],          4'he) ^
                  gf_mul4(s[c][2'(r + 1)],  4'hb) ^
                  gf_mul4(s[c][2'(r + 2)],  4'hd) ^
                  gf_mul4(s[c][2'(r + 3)],  4'h9);
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/mod_dec_rom256.sv
// -----------------------------------------------------------------------------
// mod_dec_rom256
// 256x8 AES inverse S-box with a registered output (1-cycle read latency).
// Ports:
//   clk    in  : clock, rising edge
//   resetn in  : synchronous active-low reset, clears the output register
//   addr   in  : byte to substitute
//   data   out : InvSubBytes(addr) from the previous cycle
// -----------------------------------------------------------------------------
module mod_dec_rom256
  import aes256_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  byte_t addr,
  output byte_t data
);

  // Entry 0 is the most significant byte of the first row.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
    128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e,
    128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692,
    128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
    128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
    128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
    128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f,
    128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
    128'h172b047e_ba77d626_e1691463_55210c7d
  };

  // NOTE: the table is a constant, so only the read register is reset; a
  // reset on the array itself would turn the ROM into 2048 flops.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data <= '0;
    end else begin
      data <= INV_SBOX[addr];
    end
  end

endmodule

// File: rtl/aes256_dec_fsm.sv
// -----------------------------------------------------------------------------
// aes256_dec_fsm
// Iterative AES-256 decryptor: one 128-bit block in, one out, fixed latency of
// 281 cycles from the accepting edge. InvSubBytes is done one byte per cycle
// through a shared registered inverse S-box.
// Ports:
//   clk              in       : clock, rising edge
//   resetn           in       : synchronous active-low reset
//   ctrl_dataIn_dec  in       : ciphertext strobe, honoured only in IDLE
//   dec_dataIn       in [127] : ciphertext, byte k = bits [8k+7:8k]
//   dec_keyAddr      out [3:0]: round-key index for the external key ROM
//   dec_keyIn        in [127] : round key, valid one cycle after dec_keyAddr
//   dec_dataOut      out[127] : plaintext, held until the next block completes
//   ctrl_dataOut_dec out      : one-cycle pulse qualifying dec_dataOut
// -----------------------------------------------------------------------------
module aes256_dec_fsm
  import aes256_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         ctrl_dataIn_dec,
  input  logic [127:0] dec_dataIn,
  output logic [3:0]   dec_keyAddr,
  input  logic [127:0] dec_keyIn,
  output logic [127:0] dec_dataOut,
  output logic         ctrl_dataOut_dec
);

  localparam logic [3:0] ROUND_INIT = 4'(AES_ROUNDS);
  localparam logic [3:0] CNT_LAST   = 4'(N - 1);

  dec_state_t state_q, state_d;
  byte_mat_t  st_q;
  logic [3:0] round_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_prev;
  byte_t      rom_addr;
  byte_t      rom_data;

  // Decoded per-state datapath actions.
  logic ld_in, do_ark, do_shf, do_sub, do_subw, do_mix, do_done;

  // The key ROM follows the round counter; it only moves on ISHF entry, so the
  // key is settled long before the ARK that uses it.
  assign dec_keyAddr = round_q;

  // ROM is read for byte cnt while the byte returned from the previous read
  // is written back to cnt-1.
  assign cnt_prev = cnt_q - 4'd1;
  assign rom_addr = st_q[cnt_q[3:2]][cnt_q[1:0]];

  mod_dec_rom256 u_rom (
    .clk    (clk),
    .resetn (resetn),
    .addr   (rom_addr),
    .data   (rom_data)
  );

  // NOTE: state is updated with <= so every register samples the pre-edge
  // values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first, so any path that does not assign cannot infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (ctrl_dataIn_dec) state_d = ARK;
      ARK: begin
        if (round_q == ROUND_INIT) state_d = ISHF;
        else if (round_q != 4'd0)  state_d = IMIX;
        else                       state_d = DONE;
      end
      ISHF:    state_d = ISUB;
      ISUB:    if (cnt_q == CNT_LAST) state_d = ISUBW;
      ISUBW:   state_d = ARK;
      IMIX:    state_d = ISHF;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_in   = 1'b0;
    do_ark  = 1'b0;
    do_shf  = 1'b0;
    do_sub  = 1'b0;
    do_subw = 1'b0;
    do_mix  = 1'b0;
    do_done = 1'b0;
    case (state_q)
      IDLE:    ld_in   = ctrl_dataIn_dec;
      ARK:     do_ark  = 1'b1;
      ISHF:    do_shf  = 1'b1;
      ISUB:    do_sub  = 1'b1;
      ISUBW:   do_subw = 1'b1;
      IMIX:    do_mix  = 1'b1;
      DONE:    do_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st_q             <= '0;
      round_q          <= ROUND_INIT;
      cnt_q            <= '0;
      dec_dataOut      <= '0;
      ctrl_dataOut_dec <= 1'b0;
    end else begin
      ctrl_dataOut_dec <= 1'b0;

      if (ld_in) begin
        st_q    <= dec_dataIn;
        round_q <= ROUND_INIT;
      end

      // The initial whitening ARK is the only one followed directly by ISHF,
      // so it steps the round itself; later rounds step in IMIX.
      if (do_ark) begin
        st_q <= st_q ^ dec_keyIn;
        if (round_q == ROUND_INIT) round_q <= ROUND_INIT - 4'd1;
      end

      if (do_shf) begin
        st_q  <= inv_shift_rows(st_q);
        cnt_q <= '0;
      end

      if (do_sub) begin
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q != 4'd0) st_q[cnt_prev[3:2]][cnt_prev[1:0]] <= rom_data;
      end

      // Last S-box result (byte 15) arrives one cycle after the counter ends.
      if (do_subw) st_q[3][3] <= rom_data;

      if (do_mix) begin
        st_q    <= inv_mix_columns(st_q);
        round_q <= round_q - 4'd1;
      end

      // Reload the round so IDLE presents key 14 to the ROM ahead of the next
      // block's first ARK.
      if (do_done) begin
        dec_dataOut      <= st_q;
        ctrl_dataOut_dec <= 1'b1;
        round_q          <= ROUND_INIT;
      end
    end
  end

endmodule

// File: tb/tb_aes256_dec_fsm.sv
// -----------------------------------------------------------------------------
// tb_aes256_dec_fsm
// Directed bench for aes256_dec_fsm. Round keys come from a key expansion and
// S-boxes built here from GF(2^8) arithmetic; a reference inverse cipher gives
// expected plaintexts where no published vector exists.
// -----------------------------------------------------------------------------
module tb_aes256_dec_fsm;
  import aes256_pkg::*;

  localparam logic [127:0] FIPS_CT = 128'h8960494b9049fcea_bf456751cab7a28e;
  localparam logic [127:0] FIPS_PT = 128'hffeeddccbbaa9988_7766554433221100;
  localparam logic [127:0] CT2     = 128'h0123456789abcdef_fedcba9876543210;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ctrl_dataIn_dec;
  logic [127:0] dec_dataIn;
  logic [3:0]   dec_keyAddr;
  logic [127:0] dec_keyIn;
  logic [127:0] dec_dataOut;
  logic         ctrl_dataOut_dec;

  always #5 clk = ~clk;

  aes256_dec_fsm dut (
    .clk              (clk),
    .resetn           (resetn),
    .ctrl_dataIn_dec  (ctrl_dataIn_dec),
    .dec_dataIn       (dec_dataIn),
    .dec_keyAddr      (dec_keyAddr),
    .dec_keyIn        (dec_keyIn),
    .dec_dataOut      (dec_dataOut),
    .ctrl_dataOut_dec (ctrl_dataOut_dec)
  );

  // External key ROM: one cycle read latency.
  logic [127:0] rk [16];
  always @(posedge clk) dec_keyIn <= rk[dec_keyAddr];

  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];
  logic [7:0] w [60][4];

  int total = 0;
  int bad   = 0;

  int           edge_n, pulse_n, first_edge, last_edge, unstable;
  logic [127:0] first_out, last_out;
  int           ark_q[$];
  logic [3:0]   prev_addr;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (gmul(a, 8'(b)) == 8'h01) return 8'(b);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] v, s;
    for (int a = 0; a < 256; a++) begin
      v = ginv(8'(a));
      s = v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
      sbox[a]  = s;
      isbox[s] = 8'(a);
    end
  endtask

  // AES-256 expansion of key bytes 00,01,...,1f.
  task automatic expand_key_fips();
    logic [7:0] t [4];
    logic [7:0] tmp, rcon;
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < 4; b++) w[i][b] = 8'(4 * i + b);
    rcon = 8'h01;
    for (int i = 8; i < 60; i++) begin
      for (int b = 0; b < 4; b++) t[b] = w[i-1][b];
      if (i % 8 == 0) begin
        tmp  = t[0];
        t[0] = sbox[t[1]] ^ rcon;
        t[1] = sbox[t[2]];
        t[2] = sbox[t[3]];
        t[3] = sbox[tmp];
        rcon = gmul(rcon, 8'h02);
      end else if (i % 8 == 4) begin
        for (int b = 0; b < 4; b++) t[b] = sbox[t[b]];
      end
      for (int b = 0; b < 4; b++) w[i][b] = w[i-8][b] ^ t[b];
    end
    for (int r = 0; r < 15; r++)
      for (int k = 0; k < 16; k++) rk[r][8*k +: 8] = w[4*r + k/4][k%4];
    rk[15] = '0;
  endtask

  // Textbook inverse cipher on a [row][col] byte array using the current rk[].
  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   a [4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = ct[8*(4*c+r) +: 8] ^ rk[14][8*(4*c+r) +: 8];
    for (int rnd = 13; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][(c+r)%4] = isbox[s[r][c]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = t[r][c] ^ rk[rnd][8*(4*c+r) +: 8];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) a[r] = t[r][c];
        if (rnd > 0) begin
          s[0][c] = gmul(a[0],8'h0e) ^ gmul(a[1],8'h0b) ^ gmul(a[2],8'h0d) ^ gmul(a[3],8'h09);
          s[1][c] = gmul(a[0],8'h09) ^ gmul(a[1],8'h0e) ^ gmul(a[2],8'h0b) ^ gmul(a[3],8'h0d);
          s[2][c] = gmul(a[0],8'h0d) ^ gmul(a[1],8'h09) ^ gmul(a[2],8'h0e) ^ gmul(a[3],8'h0b);
          s[3][c] = gmul(a[0],8'h0b) ^ gmul(a[1],8'h0d) ^ gmul(a[2],8'h09) ^ gmul(a[3],8'h0e);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = a[r];
        end
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[8*(4*c+r) +: 8] = s[r][c];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic begin_block();
    edge_n     = -1;
    pulse_n    = 0;
    first_edge = -1;
    last_edge  = -1;
    first_out  = '0;
    last_out   = '0;
    unstable   = 0;
    ark_q.delete();
    prev_addr  = dec_keyAddr;
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    if (ctrl_dataOut_dec) begin
      pulse_n++;
      if (first_edge < 0) begin
        first_edge = edge_n;
        first_out  = dec_dataOut;
      end
      last_edge = edge_n;
      last_out  = dec_dataOut;
    end
    if (dut.state_q == ARK) begin
      ark_q.push_back(int'(dec_keyAddr));
      if (dec_keyAddr != prev_addr) unstable++;
    end
    prev_addr = dec_keyAddr;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) step();
  endtask

  initial begin
    logic [127:0] exp2, expz;
    int           hold_bad;

    build_tables();
    expand_key_fips();

    resetn          = 1'b0;
    ctrl_dataIn_dec = 1'b0;
    dec_dataIn      = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("rst_dout",  dec_dataOut, '0);
    check("rst_pulse", 128'(ctrl_dataOut_dec), '0);
    check("rst_kaddr", 128'(dec_keyAddr), 128'd14);
    check("rst_state", 128'(dut.state_q), 128'(IDLE));
    resetn = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // FIPS-197 C.3 vector, single-cycle strobe.
    dec_dataIn      = FIPS_CT;
    ctrl_dataIn_dec = 1'b1;
    begin_block();
    step();
    ctrl_dataIn_dec = 1'b0;
    run_to(300);
    check("fips_pulses", 128'(pulse_n), 128'd1);
    check("fips_edge",   128'(first_edge), 128'd281);
    check("fips_pt",     first_out, FIPS_PT);
    check("ark_count",   128'(ark_q.size()), 128'd15);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("ark_addr%0d", i),
            128'((i < ark_q.size()) ? ark_q[i] : 99), 128'(14 - i));
    end
    check("ark_addr_stable", 128'(unstable), 128'd0);

    // Strobe held high for the whole block while the input changes underneath.
    exp2            = model_dec(CT2);
    dec_dataIn      = FIPS_CT;
    ctrl_dataIn_dec = 1'b1;
    begin_block();
    step();
    while (edge_n < 600) begin
      if (edge_n == 5) dec_dataIn = CT2;
      step();
      if (edge_n == 282) ctrl_dataIn_dec = 1'b0;
    end
    check("hammer_pulses", 128'(pulse_n), 128'd2);
    check("hammer_edge1",  128'(first_edge), 128'd281);
    check("hammer_pt1",    first_out, FIPS_PT);
    check("hammer_edge2",  128'(last_edge), 128'd563);
    check("hammer_pt2",    last_out, exp2);

    // Reset at E0+150 aborts the block; a strobe on the first edge after is taken.
    dec_dataIn      = FIPS_CT;
    ctrl_dataIn_dec = 1'b1;
    begin_block();
    step();
    ctrl_dataIn_dec = 1'b0;
    run_to(149);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("abort_pulse", 128'(ctrl_dataOut_dec), '0);
    check("abort_dout",  dec_dataOut, '0);
    check("abort_state", 128'(dut.state_q), 128'(IDLE));
    check("abort_kaddr", 128'(dec_keyAddr), 128'd14);
    dec_dataIn      = FIPS_CT;
    ctrl_dataIn_dec = 1'b1;
    begin_block();
    step();
    ctrl_dataIn_dec = 1'b0;
    run_to(300);
    check("restart_pulses", 128'(pulse_n), 128'd1);
    check("restart_edge",   128'(first_edge), 128'd281);
    check("restart_pt",     first_out, FIPS_PT);

    // All-zero ciphertext and keys, then 100 idle cycles of hold.
    for (int i = 0; i < 16; i++) rk[i] = '0;
    repeat (2) step();
    expz            = model_dec('0);
    dec_dataIn      = '0;
    ctrl_dataIn_dec = 1'b1;
    begin_block();
    step();
    ctrl_dataIn_dec = 1'b0;
    run_to(300);
    check("zero_pulses", 128'(pulse_n), 128'd1);
    check("zero_edge",   128'(first_edge), 128'd281);
    check("zero_pt",     first_out, expz);
    hold_bad = 0;
    repeat (100) begin
      step();
      if (dec_dataOut !== expz) hold_bad++;
    end
    check("hold_dout",   128'(hold_bad), '0);
    check("hold_pulses", 128'(pulse_n), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
